// File: rtl/sel_shift_pipe_if.sv
// -----------------------------------------------------------------------------
// sel_shift_pipe_if
// Streaming bus bundle for sel_shift_pipe.
//   Operand side : in_valid, in_ready, a, b, c (DW each), sat_en
//   Result side  : out_valid, out_ready, x, z (OW each), sat_flag, sat_cnt (CW)
// Data fields are carried as plain vectors; the datapath applies the signed
// interpretation internally.
//   master : the environment (drives operands, accepts results)
//   slave  : the datapath block
// -----------------------------------------------------------------------------
interface sel_shift_pipe_if #(
    parameter int DW = 64,
    parameter int OW = 32,
    parameter int CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic          sat_en;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] x;
    logic [OW-1:0] z;
    logic          sat_flag;
    logic [CW-1:0] sat_cnt;

    modport master (
        output in_valid, a, b, c, sat_en, out_ready,
        input  in_ready, out_valid, x, z, sat_flag, sat_cnt
    );

    modport slave (
        input  in_valid, a, b, c, sat_en, out_ready,
        output in_ready, out_valid, x, z, sat_flag, sat_cnt
    );
endinterface

// File: rtl/sel_shift_pipe.sv
// -----------------------------------------------------------------------------
// sel_shift_pipe
// Three-stage valid/ready add-compare-select-shift datapath with a per-beat
// choice of truncating or saturating narrowing from DW to OW bits.
//   S1: d = a+b, e = a+c, f = a-b
//   S2: lt = d<e (signed), eq = d==e, g = lt ? e : d, h = eq ? f : g
//   S3: x = narrow(h << (lt ? SH : 0)), z = narrow(g >>> (eq ? SH : 0))
// All stages advance together whenever the output register is empty or being
// drained, so in_ready is that same advance condition.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : sel_shift_pipe_if slave modport (operand and result streams)
// A result emerges after the third rising edge, counting the edge that
// accepts the beat; the pipeline holds at most three beats.
// -----------------------------------------------------------------------------
module sel_shift_pipe #(
    parameter int DW = 64,
    parameter int OW = 32,
    parameter int SH = 1,
    parameter int CW = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    sel_shift_pipe_if.slave   bus
);
    localparam logic [OW-1:0] OUT_MIN = OW'(1) << (OW-1);
    localparam logic [OW-1:0] OUT_MAX = ~OUT_MIN;

    // ---------------- stage registers ----------------
    logic                 v1_q, v2_q, out_valid_q;
    logic signed [DW-1:0] d_q, e_q, f_q;
    logic                 se1_q, se2_q;
    logic signed [DW-1:0] g_q, h_q;
    logic                 lt_q, eq_q;
    logic        [OW-1:0] x_q, z_q;
    logic                 sat_flag_q;
    logic        [CW-1:0] sat_cnt_q;

    logic adv;
    assign adv = !out_valid_q || bus.out_ready;

    // ---------------- S1: capture sums/difference ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q  <= 1'b0;
            d_q   <= '0;
            e_q   <= '0;
            f_q   <= '0;
            se1_q <= 1'b0;
        end else if (adv) begin
            v1_q  <= bus.in_valid;
            d_q   <= $signed(bus.a) + $signed(bus.b);
            e_q   <= $signed(bus.a) + $signed(bus.c);
            f_q   <= $signed(bus.a) - $signed(bus.b);
            se1_q <= bus.sat_en;
        end
    end

    // ---------------- S2: compare and select ----------------
    logic                 lt_d, eq_d;
    logic signed [DW-1:0] g_d, h_d;

    always_comb begin
        lt_d = d_q < e_q;
        eq_d = d_q == e_q;
        g_d  = lt_d ? e_q : d_q;
        h_d  = eq_d ? f_q : g_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v2_q  <= 1'b0;
            g_q   <= '0;
            h_q   <= '0;
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
            se2_q <= 1'b0;
        end else if (adv) begin
            v2_q  <= v1_q;
            g_q   <= g_d;
            h_q   <= h_d;
            lt_q  <= lt_d;
            eq_q  <= eq_d;
            se2_q <= se1_q;
        end
    end

    // ---------------- S3: shift and narrow ----------------
    logic signed [DW-1:0] xs, zs;

    always_comb begin
        xs = lt_q ? (h_q << SH) : h_q;
        zs = eq_q ? (g_q >>> SH) : g_q;
    end

    // Lane 0 carries x, lane 1 carries z; both narrow identically.
    logic [DW-1:0] lane_in  [2];
    logic [OW-1:0] lane_out [2];
    logic          lane_sat [2];

    assign lane_in[0] = xs;
    assign lane_in[1] = zs;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_narrow
            // A value fits in OW signed bits when every bit from the OW sign
            // position upward matches; with OW == DW this is a single bit and
            // always fits, so saturation can never fire.
            logic fits;
            assign fits = (lane_in[gi][DW-1:OW-1] == '0) ||
                          (lane_in[gi][DW-1:OW-1] == '1);
            assign lane_sat[gi] = se2_q && !fits;
            assign lane_out[gi] = lane_sat[gi] ? (lane_in[gi][DW-1] ? OUT_MIN : OUT_MAX)
                                               : lane_in[gi][OW-1:0];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            x_q         <= '0;
            z_q         <= '0;
            sat_flag_q  <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v2_q;
            x_q         <= lane_out[0];
            z_q         <= lane_out[1];
            sat_flag_q  <= lane_sat[0] || lane_sat[1];
        end
    end

    // Counts only transferred beats; invalid slots may carry a stale flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_cnt_q <= '0;
        end else if (out_valid_q && bus.out_ready && sat_flag_q && (sat_cnt_q != '1)) begin
            sat_cnt_q <= sat_cnt_q + CW'(1);
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.x         = x_q;
    assign bus.z         = z_q;
    assign bus.sat_flag  = sat_flag_q;
    assign bus.sat_cnt   = sat_cnt_q;
endmodule

// File: tb/tb_sel_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_sel_shift_pipe
// Directed bench for sel_shift_pipe. Main instance DW=64/OW=32/SH=1/CW=16,
// plus a CW=2 instance for counter saturation and an OW=64 instance where
// narrowing never clamps. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sel_shift_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sel_shift_pipe_if #(.DW(64), .OW(32), .CW(16)) m_if  ();
    sel_shift_pipe_if #(.DW(64), .OW(32), .CW(2))  m2_if ();
    sel_shift_pipe_if #(.DW(64), .OW(64), .CW(16)) m3_if ();

    sel_shift_pipe #(.DW(64), .OW(32), .SH(1), .CW(16)) u_dut (
        .clk_i (clk), .rst_ni(rst_n), .bus(m_if.slave));
    sel_shift_pipe #(.DW(64), .OW(32), .SH(1), .CW(2)) u_dut_cw2 (
        .clk_i (clk), .rst_ni(rst_n), .bus(m2_if.slave));
    sel_shift_pipe #(.DW(64), .OW(64), .SH(1), .CW(16)) u_dut_ow64 (
        .clk_i (clk), .rst_ni(rst_n), .bus(m3_if.slave));

    typedef struct {
        logic [63:0] a, b, c;
        logic        se;
        logic [31:0] x, z;
        logic        f;
    } vec_t;

    vec_t vt [12];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_vec(input int idx);
        m_if.a      = vt[idx].a;
        m_if.b      = vt[idx].b;
        m_if.c      = vt[idx].c;
        m_if.sat_en = vt[idx].se;
    endtask

    // One isolated beat: checks latency, result, flag and counter update.
    task automatic run_single(input int idx);
        int lat;
        @(negedge clk);
        drive_vec(idx);
        m_if.in_valid  = 1'b1;
        m_if.out_ready = 1'b1;
        #1;
        check("single_in_ready", m_if.in_ready, 1);
        lat = 0;
        do begin
            @(negedge clk);
            m_if.in_valid = 1'b0;
            lat++;
        end while (!m_if.out_valid && lat < 10);
        check("latency", lat, 3);
        check("single_x", m_if.x, vt[idx].x);
        check("single_z", m_if.z, vt[idx].z);
        check("single_flag", m_if.sat_flag, vt[idx].f);
        if (vt[idx].f) exp_cnt++;
        @(negedge clk);
        check("single_sat_cnt", m_if.sat_cnt, exp_cnt);
        check("single_no_dup", m_if.out_valid, 0);
        $display("single vec %0d x=%h z=%h flag=%b cnt=%0d", idx, m_if.x, m_if.z,
                 m_if.sat_flag, m_if.sat_cnt);
    endtask

    task automatic run_stream();
        int          ni = 0;
        int          no = 0;
        int          cyc = 0;
        logic [15:0] pat = 16'hB2D6;
        logic        stalled = 1'b0;
        while (no < 10 && cyc < 200) begin
            @(negedge clk);
            if (stalled) check("stall_valid", m_if.out_valid, 1);
            if (m_if.out_valid) begin
                check("stream_x", m_if.x, vt[no].x);
                check("stream_z", m_if.z, vt[no].z);
                check("stream_flag", m_if.sat_flag, vt[no].f);
            end
            check("stream_sat_cnt", m_if.sat_cnt, exp_cnt);
            m_if.out_ready = pat[cyc % 16];
            if (ni < 10) begin
                drive_vec(ni);
                m_if.in_valid = 1'b1;
            end else begin
                m_if.in_valid = 1'b0;
            end
            #1;
            check("in_ready_adv", m_if.in_ready, !m_if.out_valid || m_if.out_ready);
            stalled = m_if.out_valid && !m_if.out_ready;
            if (m_if.out_valid && m_if.out_ready) begin
                $display("stream beat %0d x=%h z=%h flag=%b", no, m_if.x, m_if.z, m_if.sat_flag);
                if (vt[no].f) exp_cnt++;
                no++;
            end
            if (m_if.in_valid && m_if.in_ready) ni++;
            cyc++;
        end
        check("stream_beats", no, 10);
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stream_no_extra", m_if.out_valid, 0);
        end
        check("stream_final_cnt", m_if.sat_cnt, exp_cnt);
    endtask

    task automatic run_reset_midstream();
        @(negedge clk);
        m_if.out_ready = 1'b0;
        drive_vec(5);
        for (int i = 0; i < 3; i++) begin
            m_if.in_valid = 1'b1;
            #1;
            check("rst_push_ready", m_if.in_ready, 1);
            @(negedge clk);
        end
        m_if.in_valid = 1'b0;
        check("rst_pre_valid", m_if.out_valid, 1);
        check("rst_pre_in_ready", m_if.in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", m_if.out_valid, 0);
        check("rst_async_x", m_if.x, 0);
        check("rst_async_z", m_if.z, 0);
        check("rst_async_flag", m_if.sat_flag, 0);
        check("rst_async_cnt", m_if.sat_cnt, 0);
        $display("mid-stream reset applied, out_valid=%b cnt=%0d", m_if.out_valid, m_if.sat_cnt);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        #1;
        check("rst_release_ready", m_if.in_ready, 1);
        run_single(2);
    endtask

    task automatic run_cw2();
        int   fires = 0;
        int   exp2 = 0;
        logic pending = 1'b0;
        m2_if.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pending) begin
                check("cw2_cnt", m2_if.sat_cnt, exp2);
                $display("cw2 beat %0d cnt=%0d", fires, m2_if.sat_cnt);
                pending = 1'b0;
            end
            if (m2_if.out_valid) begin
                check("cw2_flag", m2_if.sat_flag, 1);
                fires++;
                exp2 = (fires > 3) ? 3 : fires;
                pending = 1'b1;
            end
            m2_if.in_valid = (i < 5);
        end
        check("cw2_beats", fires, 5);
    endtask

    task automatic run_ow64();
        logic [63:0] ex [2];
        int          got = 0;
        ex[0] = 64'h0000_0200_0000_0002;
        ex[1] = 64'h8000_0000_0000_0002;
        m3_if.out_ready = 1'b1;
        m3_if.sat_en    = 1'b1;
        m3_if.b         = 64'd0;
        m3_if.c         = 64'd1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m3_if.out_valid && got < 2) begin
                check("ow64_x", m3_if.x, ex[got]);
                check("ow64_flag", m3_if.sat_flag, 0);
                if (got == 0) check("ow64_z", m3_if.z, 64'h0000_0100_0000_0001);
                $display("ow64 beat %0d x=%h z=%h flag=%b", got, m3_if.x, m3_if.z, m3_if.sat_flag);
                got++;
            end
            m3_if.in_valid = (i < 2);
            m3_if.a = (i == 0) ? 64'h0000_0100_0000_0000 : 64'h4000_0000_0000_0000;
        end
        check("ow64_beats", got, 2);
        check("ow64_cnt", m3_if.sat_cnt, 0);
    endtask

    initial begin
        vt[0]  = '{64'd5, 64'd3, 64'd1, 1'b0, 32'd8, 32'd8, 1'b0};
        vt[1]  = '{64'd5, 64'd2, 64'd2, 1'b0, 32'd3, 32'd3, 1'b0};
        vt[2]  = '{64'd1, 64'd1, 64'd4, 1'b0, 32'd10, 32'd5, 1'b0};
        vt[3]  = '{64'hFFFF_FFFF_FFFF_FFF7, 64'd0, 64'd0, 1'b0, 32'hFFFF_FFF7, 32'hFFFF_FFFB, 1'b0};
        vt[4]  = '{64'h0000_0100_0000_0000, 64'd0, 64'd1, 1'b0, 32'd2, 32'd1, 1'b0};
        vt[5]  = '{64'h0000_0100_0000_0000, 64'd0, 64'd1, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
        vt[6]  = '{64'hFFFF_FF00_0000_0000, 64'd0, 64'd1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1};
        vt[7]  = '{64'd1, 64'd1, 64'd4, 1'b1, 32'd10, 32'd5, 1'b0};
        vt[8]  = '{64'd100, 64'hFFFF_FFFF_FFFF_FFCE, 64'd10, 1'b0, 32'd220, 32'd110, 1'b0};
        vt[9]  = '{64'h0000_0000_7FFF_FFFF, 64'd0, 64'd0, 1'b1, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b0};
        vt[10] = '{64'h0000_0000_4000_0000, 64'd0, 64'd1, 1'b1, 32'h7FFF_FFFF, 32'h4000_0001, 1'b1};
        vt[11] = '{64'd3, 64'd7, 64'd0, 1'b0, 32'd10, 32'd10, 1'b0};

        rst_n = 1'b0;
        m_if.in_valid  = 1'b0; m_if.out_ready  = 1'b0; m_if.sat_en  = 1'b0;
        m_if.a  = '0; m_if.b  = '0; m_if.c  = '0;
        m2_if.in_valid = 1'b0; m2_if.out_ready = 1'b0; m2_if.sat_en = 1'b1;
        m2_if.a = 64'h0000_0100_0000_0000; m2_if.b = '0; m2_if.c = 64'd1;
        m3_if.in_valid = 1'b0; m3_if.out_ready = 1'b0; m3_if.sat_en = 1'b0;
        m3_if.a = '0; m3_if.b = '0; m3_if.c = '0;

        repeat (2) @(negedge clk);
        check("reset_valid", m_if.out_valid, 0);
        check("reset_x", m_if.x, 0);
        check("reset_z", m_if.z, 0);
        check("reset_flag", m_if.sat_flag, 0);
        check("reset_cnt", m_if.sat_cnt, 0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", m_if.in_ready, 1);
        $display("reset released");

        for (int i = 0; i < 12; i++) run_single(i);
        run_stream();
        run_reset_midstream();
        run_cw2();
        run_ow64();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
